uop_issue_arbiter: RTL

Shares one `uop_block` datapath between `N_REQ` requesters. Each cycle it grants at most one request round-robin and registers that request's operands into the block. It tracks each operation in flight with its requester ID for the block's fixed pipeline latency, then captures the result into a response FIFO. Issue is credit-gated so no result is ever lost to response backpressure. The block sits between requester ports and a `uop_block` instance, whose `src`/`shamt`/`dst` connect to `blk_*`.

---
 rtl/uop_issue_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uop_issue_arbiter.sv
// Round-robin issue arbiter in front of a shared fixed-latency uop_block. Tracks in-flight
// requester IDs and queues results in a credit-protected response FIFO.
module uop_issue_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned W          = 32,
    parameter int unsigned LAT        = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*W-1:0]            req_src,
    input  logic [N_REQ*$clog2(W)-1:0]    req_shamt,
    output logic [W-1:0]                  blk_src,
    output logic [$clog2(W)-1:0]          blk_shamt,
    input  logic [W-1:0]                  blk_dst,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [W-1:0]                  rsp_data,
    output logic [$clog2(N_REQ)-1:0]      rsp_id,
    output logic                          idle
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FW = $clog2(FIFO_DEPTH + LAT + 2);

    logic [IW-1:0]         last_q;
    logic [IW-1:0]         win;
    logic [IW-1:0]         cand;
    logic                  grant;
    logic                  issue_ok;
    logic                  hs;
    logic [W-1:0]          sel_src;
    logic [SW-1:0]         sel_shamt;
    logic [W-1:0]          src_q;
    logic [SW-1:0]         shamt_q;
    logic [LAT:0]          vld_q;
    logic [LAT:0][IW-1:0]  id_q;
    logic [FW-1:0]         inflight;
    logic [FW-1:0]         used;
    logic                  cap;
    logic                  pop;
    logic [W-1:0]          fdata_q [FIFO_DEPTH];
    logic [IW-1:0]         fid_q   [FIFO_DEPTH];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail_q;
    logic [CW-1:0]         count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= int'(LAT); i++) begin
            inflight = inflight + FW'(vld_q[i]);
        end
    end

    // A pop this cycle frees its slot only once count_q has dropped, i.e. next cycle.
    assign used     = FW'(count_q) + inflight;
    assign issue_ok = rst_n && (used < FW'(FIFO_DEPTH));

    always_comb begin
        grant = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = IW'((int'(last_q) + k) % int'(N_REQ));
            if (!grant && req_valid[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (issue_ok && grant) begin
            req_ready[win] = 1'b1;
        end
    end

    assign hs = issue_ok && grant;

    always_comb begin
        sel_src   = '0;
        sel_shamt = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win == IW'(i)) begin
                sel_src   = req_src[i*W +: W];
                sel_shamt = req_shamt[i*SW +: SW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= IW'(N_REQ - 1);
            src_q   <= '0;
            shamt_q <= '0;
            vld_q   <= '0;
            id_q    <= '0;
        end else begin
            if (hs) begin
                last_q  <= win;
                src_q   <= sel_src;
                shamt_q <= sel_shamt;
            end
            vld_q[0] <= hs;
            id_q[0]  <= win;
            for (int i = 1; i <= int'(LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign blk_src   = src_q;
    assign blk_shamt = shamt_q;

    assign cap       = vld_q[LAT];
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (cap) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            if (cap && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!cap && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (cap) begin
            fdata_q[tail_q] <= blk_dst;
            fid_q[tail_q]   <= id_q[LAT];
        end
    end

    assign rsp_data = rsp_valid ? fdata_q[head_q] : '0;
    assign rsp_id   = rsp_valid ? fid_q[head_q] : '0;
    assign idle     = (inflight == '0) && (count_q == '0);

    assert property (@(posedge clk) disable iff (!rst_n)
        !(cap && (count_q == CW'(FIFO_DEPTH))));

endmodule
